// File: rtl/clock_pkg.sv
// Shared encodings and field limits for the time-entry controller.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    EDIT_HR  = 2'd1,
    EDIT_MIN = 2'd2
  } state_t;

  localparam logic [1:0] FIELD_RUN = 2'b00;
  localparam logic [1:0] FIELD_HR  = 2'b01;
  localparam logic [1:0] FIELD_MIN = 2'b10;

  localparam logic [7:0] MAX_HR24 = 8'd23;
  localparam logic [7:0] MAX_HR12 = 8'd11;
  localparam logic [7:0] MAX_MIN  = 8'd59;

endpackage

// File: rtl/btn_conditioner.sv
// Synchronizes a debounced button, emits a 1-cycle press pulse and,
// optionally, auto-repeat pulses while the button stays held.
module btn_conditioner #(
  parameter bit          REPEAT_EN     = 1'b1,
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned CW            = 32
) (
  input  logic clk,
  input  logic RESET,
  input  logic btn,
  output logic pulse
);

  localparam logic [CW-1:0] REP_D   = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] REP_P   = CW'(REPEAT_PERIOD);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic          sync_p0, sync_p1, prev_p2;
  logic [CW-1:0] holdCnt;
  logic          repeating;
  logic          repTick;

  // holdCnt equals the number of cycles since the press pulse, so the first
  // repeat lands REPEAT_DELAY cycles after the press step.
  always_comb begin
    repTick = 1'b0;
    if (REPEAT_EN && sync_p1)
      repTick = repeating ? (holdCnt == REP_P) : (holdCnt == REP_D);
  end

  assign pulse = (sync_p1 & ~prev_p2) | repTick;

  always_ff @(posedge clk) begin
    if (RESET) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      prev_p2   <= 1'b0;
      holdCnt   <= '0;
      repeating <= 1'b0;
    end else begin
      // synchronizer -> edge-detect stage
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
      if (!REPEAT_EN || !sync_p1) begin
        holdCnt   <= '0;
        repeating <= 1'b0;
      end else if (repTick) begin
        holdCnt   <= CNT_ONE;
        repeating <= 1'b1;
      end else begin
        holdCnt <= holdCnt + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/time_setter.sv
// Pushbutton hours/minutes editor that stops the time block while editing
// and reloads it with the edited value on the enOUT rising edge.
module time_setter
  import clock_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD = 5_000_000,
  parameter int unsigned TIMEOUT       = 500_000_000,
  parameter int unsigned CW            = 32
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        btnSet,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic [15:0] timeIN_24,
  output logic        enOUT,
  output logic [15:0] dataOUT_24,
  output logic [15:0] dataOUT_12,
  output logic [1:0]  editField
);

  localparam logic [CW-1:0] IDLE_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  function automatic logic [7:0] wrapInc(input logic [7:0] v, input logic [7:0] maxV);
    return (v == maxV) ? 8'd0 : v + 8'd1;
  endfunction

  function automatic logic [7:0] wrapDec(input logic [7:0] v, input logic [7:0] maxV);
    return (v == 8'd0) ? maxV : v - 8'd1;
  endfunction

  function automatic logic [7:0] hrTo12(input logic [7:0] h);
    return (h > MAX_HR12) ? h - 8'd12 : h;
  endfunction

  logic setP, upP, downP;

  btn_conditioner #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_PERIOD(REPEAT_PERIOD), .CW(CW))
    uSet  (.clk(clk), .RESET(RESET), .btn(btnSet),  .pulse(setP));
  btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_PERIOD(REPEAT_PERIOD), .CW(CW))
    uUp   (.clk(clk), .RESET(RESET), .btn(btnUp),   .pulse(upP));
  btn_conditioner #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY),
                    .REPEAT_PERIOD(REPEAT_PERIOD), .CW(CW))
    uDown (.clk(clk), .RESET(RESET), .btn(btnDown), .pulse(downP));

  state_t        state, stateNext;
  logic [7:0]    hr, hrNext, min, minNext;
  logic [CW-1:0] idleCnt, idleNext;
  logic          stepUp, stepDn, anyP;

  assign stepUp = upP & ~downP;
  assign stepDn = downP & ~upP;
  assign anyP   = setP | upP | downP;

  always_comb begin
    stateNext = state;
    hrNext    = hr;
    minNext   = min;
    idleNext  = '0;
    enOUT     = 1'b0;
    editField = FIELD_RUN;
    case (state)
      RUN: begin
        enOUT = 1'b1;
        if (setP) begin
          stateNext = EDIT_HR;
          hrNext    = (timeIN_24[15:8] > MAX_HR24) ? 8'd0 : timeIN_24[15:8];
          minNext   = (timeIN_24[7:0]  > MAX_MIN)  ? 8'd0 : timeIN_24[7:0];
        end
      end
      EDIT_HR: begin
        editField = FIELD_HR;
        if (setP)        stateNext = EDIT_MIN;
        else if (stepUp) hrNext    = wrapInc(hr, MAX_HR24);
        else if (stepDn) hrNext    = wrapDec(hr, MAX_HR24);
      end
      EDIT_MIN: begin
        editField = FIELD_MIN;
        if (setP)        stateNext = RUN;
        else if (stepUp) minNext   = wrapInc(min, MAX_MIN);
        else if (stepDn) minNext   = wrapDec(min, MAX_MIN);
      end
      default: stateNext = RUN;
    endcase
    // Idle timeout commits whatever is being edited.
    if (state != RUN && !anyP) begin
      if (idleCnt == IDLE_LAST) stateNext = RUN;
      else                      idleNext  = idleCnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state      <= RUN;
      hr         <= 8'd0;
      min        <= 8'd0;
      idleCnt    <= '0;
      dataOUT_24 <= 16'd0;
      dataOUT_12 <= 16'd0;
    end else begin
      state      <= stateNext;
      hr         <= hrNext;
      min        <= minNext;
      idleCnt    <= idleNext;
      // output register stage: lags hr/min by one cycle
      dataOUT_24 <= {hr, min};
      dataOUT_12 <= {hrTo12(hr), min};
    end
  end

endmodule
